// File: rtl/shifter_seq.sv
// shifter_seq: iterative barrel shifter (SLL/SRL/SRA/ROL/ROR) resolving LEVELS_PER_CYCLE levels per cycle
module shifter_seq #(
  parameter int WIDTH = 32,
  parameter int LEVELS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [WIDTH-1:0]          req_data,
  input  logic [$clog2(WIDTH)-1:0]  req_amount,
  input  logic [2:0]                req_op,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [WIDTH-1:0]          resp_data,
  output logic                      resp_illegal
);
  localparam int AW = $clog2(WIDTH);
  localparam int L = LEVELS_PER_CYCLE;
  localparam int N = (AW + L - 1) / L;
  localparam int GW = N > 1 ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] ONES = '1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [WIDTH-1:0] data_q, data_d, x;
  logic [AW-1:0] amt_q, amt_d;
  logic [2:0] op_q, op_d;
  logic sign_q, sign_d, ill_q, ill_d;
  int s;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      data_q  <= data_d;
      amt_q   <= amt_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      ill_q   <= ill_d;
    end
  end
  // amt_q is consumed L bits per cycle, so bit j always selects level g*L+j
  always_comb begin
    x = data_q;
    s = 0;
    for (int j = 0; j < L; j++) begin
      s = 1 << (int'(g_q) * L + j);
      if (|(amt_q & (AW'(1) << j)))
        x = op_q == 3'b000 ? x << s :
            op_q == 3'b100 ? (x << s) | (x >> (WIDTH - s)) :
            op_q == 3'b101 ? (x >> s) | (x << (WIDTH - s)) :
            (x >> s) | ((op_q == 3'b011 && sign_q) ? ~(ONES >> s) : '0);
    end
  end
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    data_d  = data_q;
    amt_d   = amt_q;
    op_d    = op_q;
    sign_d  = sign_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = BUSY;
        g_d     = '0;
        data_d  = req_data;
        amt_d   = req_amount;
        op_d    = req_op;
        sign_d  = req_data[WIDTH-1];
        ill_d   = !(req_op inside {3'b000, 3'b001, 3'b011, 3'b100, 3'b101});
      end
      BUSY: begin
        data_d = ill_q ? data_q : x;
        amt_d  = amt_q >> L;
        g_d    = g_q + 1'b1;
        if (g_q == GW'(N - 1)) begin
          state_d = DONE;
          g_d     = '0;
        end
      end
      DONE: state_d = resp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign req_ready    = state_q == IDLE;
  assign resp_valid   = state_q == DONE;
  assign resp_data    = data_q;
  assign resp_illegal = ill_q;
endmodule
